branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage branch target buffer (BTB) with per-entry saturating direction counters. It is the parametrised successor to the fixed "predict not-taken, flush on EX resolve" scheme in the current pipeline.
- Fetch queries it combinationally with the current PC and receives a predicted next PC.
- The EX stage sends one update per resolved branch or jump. The block also keeps performance counters used for CPI analysis.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of two and ≥ 2.
- ADDR_W, 32, PC/address width in bits.
- CTR_W, 2, width of the direction counter; must be ≥ 1.
- PERF_W, 32, width of each performance counter.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- lookup_pc  in  ADDR_W  current fetch PC (word aligned).
- pred_hit  out  1  a valid entry's tag matches lookup_pc.
- pred_taken  out  1  pred_hit and counter MSB = 1.
- pred_target  out  ADDR_W  predicted next PC.
- upd_valid  in  1  resolved control-transfer update this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  actual outcome; always 1 for J/JAL/JR.
- upd_target  in  ADDR_W  actual target (branch target or jump address).
- upd_mispredict  in  1  EX detected that the fetch-time prediction was wrong; qualified by upd_valid.
- flush_all  in  1  invalidate every entry (context switch or self-modifying code).
- perf_hits  out  PERF_W  lookups with pred_hit = 1.
- perf_updates  out  PERF_W  accepted updates.
- perf_mispredicts  out  PERF_W  updates with upd_mispredict = 1.

Behaviour:
- Addressing:
  - IDX_W = log2(ENTRIES).
  - Index = pc[IDX_W+1:2].
  - Tag = pc[ADDR_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry storage:
  - valid bit, tag, target[ADDR_W-1:2], ctr[CTR_W-1:0].
  - Target bits [1:0] are reconstructed as 00.
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] && tag[idx] == lookup tag.
  - pred_taken = pred_hit && ctr[idx][CTR_W-1].
  - pred_target = stored target when pred_taken, otherwise lookup_pc + 4 (wraps modulo 2^ADDR_W).
- Update (registered; visible to lookups from the next cycle):
  - Lookup in the same cycle as an update to the same index sees pre-update state. There is no bypass.
  - Hit (valid and tag match), upd_taken = 1: ctr increments, saturating at 2^CTR_W - 1; target is overwritten with upd_target.
  - Hit, upd_taken = 0: ctr decrements, saturating at 0; target is unchanged.
  - Miss, upd_taken = 1: allocate and overwrite the entry at that index. Set valid = 1, tag, target, and ctr = 2^(CTR_W-1) (weakly taken).
  - Miss, upd_taken = 0: no allocation; the entry is untouched.
- Flush:
  - flush_all clears all valid bits at the next edge. Tags, targets and counters are don't-care.
  - flush_all together with upd_valid: flush wins; the update is dropped, but perf counters still count it.
- Reset (RST high at an edge):
  - All valid bits 0, all ctr 0, all perf counters 0.
  - Hence after reset: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.
  - Reset overrides flush_all and upd_valid in the same cycle.
  - Reset asserted mid-sequence discards all pending state; nothing is held across reset.
- Performance counters:
  - Increment by 1 per qualifying cycle and saturate at all-ones; they never wrap.
  - perf_hits counts every cycle with pred_hit = 1; the caller gates lookup_pc validity.
- Storage must be a flop array; this block has no SRAM macros.

Decomposition:
- Shared package cpu_types_pkg holds:
  - btb_entry_t, a packed struct {valid, tag, target, ctr} built from parameter-derived widths via a parametrised typedef in the module;
  - the constant WORD_BYTES = 4, used for the +4 increment.
- One natural sub-module: sat_counter, a parametrised CTR_W up/down saturating counter step function with inputs cur, up, and output next. It is instantiated per update path and reused for the perf counters with up-only use.

Test Plan:
- Reset, then lookup_pc = 0x00000040 → pred_hit = 0, pred_taken = 0, pred_target = 0x00000044.
- Update pc = 0x40, taken, target = 0x100; next cycle lookup 0x40 → hit = 1, taken = 1, target = 0x00000100, ctr = 2. In the same cycle as the update, the lookup still shows a miss.
- Counter saturation on pc = 0x40:
  - Three further taken updates → ctr stays 3.
  - Then two not-taken updates → ctr = 1, pred_taken = 0, pred_target = 0x44, pred_hit = 1.
  - Then two more not-taken updates → ctr = 0, no underflow.
- Alias with ENTRIES = 16:
  - Allocate pc = 0x40, then taken update for pc = 0x80 (same index 0, different tag) → lookup 0x40 misses; lookup 0x80 hits with the new target.
  - A not-taken update to 0xC0 leaves the 0x80 entry intact.
- flush_all asserted with upd_valid for pc = 0x200 in the same cycle → next cycle all lookups miss, including 0x200; perf_updates incremented by 1.
- Perf counters with PERF_W = 4:
  - 20 mispredict updates → perf_mispredicts = 15 (saturated).
  - RST for one cycle mid-stream → all perf counters 0 and all entries invalid at the next edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types and constants.
package cpu_types_pkg;

  // Bytes per instruction word; sequential fetch advances by this amount.
  localparam int unsigned WORD_BYTES = 4;

  // Byte-offset bits below the word address; always zero in stored targets.
  localparam int unsigned WORD_OFS_W = 2;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX update and perf-counter signals of the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PERF_W = 32
);

  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic              flush_all;

  logic [PERF_W-1:0] perf_hits;
  logic [PERF_W-1:0] perf_updates;
  logic [PERF_W-1:0] perf_mispredicts;

  // Pipeline side: drives lookups and updates, consumes predictions.
  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_mispredict, flush_all,
    input  pred_hit, pred_taken, pred_target,
           perf_hits, perf_updates, perf_mispredicts
  );

  // Predictor side.
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_mispredict, flush_all,
    output pred_hit, pred_taken, pred_target,
           perf_hits, perf_updates, perf_mispredicts
  );

endinterface

// File: rtl/sat_counter.sv
// Up/down saturating counter step function (no state of its own).
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         up,
  output logic [W-1:0] next
);

  // Step toward all-ones or zero, holding at either end.
  always_comb begin
    next = cur;
    if (up) begin
      if (cur != {W{1'b1}}) next = cur + W'(1);
    end else begin
      if (cur != {W{1'b0}}) next = cur - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters and perf counters.
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input logic              CLK,
  input logic              RST,
  branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - WORD_OFS_W;
  localparam int unsigned TGT_W = ADDR_W - WORD_OFS_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              hit_c;
  logic              taken_c;
  logic [ADDR_W-1:0] target_c;
  logic              up_hit_c;
  logic [CTR_W-1:0]  ctr_next;
  btb_entry_t        alloc_c;

  logic [PERF_W-1:0] perf_hits_q, perf_updates_q, perf_mis_q;
  logic [PERF_W-1:0] hits_next, updates_next, mis_next;

  assign lk_idx = bus.lookup_pc[IDX_W+WORD_OFS_W-1:WORD_OFS_W];
  assign lk_tag = bus.lookup_pc[ADDR_W-1:IDX_W+WORD_OFS_W];
  assign up_idx = bus.upd_pc[IDX_W+WORD_OFS_W-1:WORD_OFS_W];
  assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+WORD_OFS_W];

  // Byte-offset bits carry no information for word-aligned PCs.
  logic unused_ofs;
  assign unused_ofs = ^{bus.lookup_pc[WORD_OFS_W-1:0], bus.upd_pc[WORD_OFS_W-1:0],
                        bus.upd_target[WORD_OFS_W-1:0]};

  // Zero-latency lookup against the current table contents.
  always_comb begin
    hit_c    = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);
    taken_c  = hit_c && btb_q[lk_idx].ctr[CTR_W-1];
    target_c = bus.lookup_pc + ADDR_W'(WORD_BYTES);
    if (taken_c) target_c = {btb_q[lk_idx].target, WORD_OFS_W'(0)};
  end

  assign bus.pred_hit    = hit_c;
  assign bus.pred_taken  = taken_c;
  assign bus.pred_target = target_c;

  // Update-side hit detection and the fresh entry used on a taken miss.
  always_comb begin
    up_hit_c      = btb_q[up_idx].valid && (btb_q[up_idx].tag == up_tag);
    alloc_c       = '0;
    alloc_c.valid = 1'b1;
    alloc_c.tag   = up_tag;
    alloc_c.target = bus.upd_target[ADDR_W-1:WORD_OFS_W];
    alloc_c.ctr   = CTR_INIT;
  end

  sat_counter #(.W(CTR_W)) u_dir_ctr (
    .cur  (btb_q[up_idx].ctr),
    .up   (bus.upd_taken),
    .next (ctr_next)
  );

  sat_counter #(.W(PERF_W)) u_perf_hits (
    .cur (perf_hits_q), .up (1'b1), .next (hits_next)
  );

  sat_counter #(.W(PERF_W)) u_perf_updates (
    .cur (perf_updates_q), .up (1'b1), .next (updates_next)
  );

  sat_counter #(.W(PERF_W)) u_perf_mis (
    .cur (perf_mis_q), .up (1'b1), .next (mis_next)
  );

  // Table update: reset beats flush, flush beats a same-cycle update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else if (bus.flush_all) begin
      for (int unsigned i = 0; i < ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else if (bus.upd_valid) begin
      if (up_hit_c) begin
        btb_q[up_idx].ctr <= ctr_next;
        if (bus.upd_taken) btb_q[up_idx].target <= bus.upd_target[ADDR_W-1:WORD_OFS_W];
      end else if (bus.upd_taken) begin
        btb_q[up_idx] <= alloc_c;
      end
    end
  end

  // Saturating perf counters; updates count even when a flush drops them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_hits_q    <= '0;
      perf_updates_q <= '0;
      perf_mis_q     <= '0;
    end else begin
      if (hit_c) perf_hits_q <= hits_next;
      if (bus.upd_valid) perf_updates_q <= updates_next;
      if (bus.upd_valid && bus.upd_mispredict) perf_mis_q <= mis_next;
    end
  end

  assign bus.perf_hits        = perf_hits_q;
  assign bus.perf_updates     = perf_updates_q;
  assign bus.perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, CTR_W=2, PERF_W=4).
module tb_branch_predictor;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned PERF_W = 4;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  branch_predictor_if #(.ADDR_W(ADDR_W), .PERF_W(PERF_W)) bus ();

  branch_predictor #(
    .ENTRIES (16),
    .ADDR_W  (ADDR_W),
    .CTR_W   (2),
    .PERF_W  (PERF_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    bit          cp;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    bit          cf;
    logic [3:0]  h;
    logic [3:0]  u;
    logic [3:0]  m;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    n_cmp;
  int    n_bad;

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  task automatic drive(input bit rst, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit um, input bit fl);
    RST                = rst;
    bus.lookup_pc      = lpc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_target     = utgt;
    bus.upd_mispredict = um;
    bus.flush_all      = fl;
  endtask

  task automatic look(input logic [31:0] lpc);
    drive(1'b0, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] lpc, input logic [31:0] upc, input bit ut,
                     input logic [31:0] utgt, input bit um, input bit fl);
    drive(1'b0, lpc, 1'b1, upc, ut, utgt, um, fl);
  endtask

  // Queue the expected response for the cycle currently being driven.
  task automatic chk(input string nm, input bit cp, input bit hit, input bit taken,
                     input logic [31:0] tgt, input bit cf, input int h, input int u,
                     input int m);
    exp_t e;
    e.cp = cp; e.hit = hit; e.taken = taken; e.tgt = tgt;
    e.cf = cf; e.h = sat4(h); e.u = sat4(u); e.m = sat4(m);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  exp_t  cur_e;
  string cur_n;
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      cur_n = name_q.pop_front();
      if (cur_e.cp) begin
        n_cmp++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !==
            {cur_e.hit, cur_e.taken, cur_e.tgt}) begin
          n_bad++;
          $display("FAIL %s pred: got hit=%0b taken=%0b target=%08h, want hit=%0b taken=%0b target=%08h",
                   cur_n, bus.pred_hit, bus.pred_taken, bus.pred_target,
                   cur_e.hit, cur_e.taken, cur_e.tgt);
        end
      end
      if (cur_e.cf) begin
        n_cmp++;
        if ({bus.perf_hits, bus.perf_updates, bus.perf_mispredicts} !==
            {cur_e.h, cur_e.u, cur_e.m}) begin
          n_bad++;
          $display("FAIL %s perf: got hits=%0d upd=%0d mis=%0d, want hits=%0d upd=%0d mis=%0d",
                   cur_n, bus.perf_hits, bus.perf_updates, bus.perf_mispredicts,
                   cur_e.h, cur_e.u, cur_e.m);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); tick();

    // Post-reset lookup.
    look(32'h40);   chk("rst_lookup", 1, 0, 0, 32'h44, 1, 0, 0, 0); tick();

    // Allocate 0x40 -> 0x100; same-cycle lookup sees the old (empty) entry.
    upd(32'h40, 32'h40, 1, 32'h100, 0, 0);
    chk("same_cyc", 1, 0, 0, 32'h44, 0, 0, 0, 0); tick();
    look(32'h40);   chk("alloc_hit", 1, 1, 1, 32'h100, 1, 0, 1, 0); tick();

    // Three more taken updates: counter pinned at 3.
    for (int k = 0; k < 3; k++) begin
      upd(32'h4, 32'h40, 1, 32'h100, 0, 0); tick();
    end
    upd(32'h4, 32'h40, 0, 32'h0, 0, 0); tick();
    look(32'h40);   chk("sat_hi", 1, 1, 1, 32'h100, 0, 0, 0, 0); tick();
    upd(32'h4, 32'h40, 0, 32'h0, 0, 0); tick();
    look(32'h40);   chk("ctr_one", 1, 1, 0, 32'h44, 0, 0, 0, 0); tick();

    // Two more not-taken: counter pinned at 0, one taken brings it to 1.
    for (int k = 0; k < 2; k++) begin
      upd(32'h4, 32'h40, 0, 32'h0, 0, 0); tick();
    end
    upd(32'h4, 32'h40, 1, 32'h104, 0, 0); tick();
    look(32'h40);   chk("no_underflow", 1, 1, 0, 32'h44, 0, 0, 0, 0); tick();

    // Taken hit overwrites target; low two bits are dropped.
    upd(32'h4, 32'h40, 1, 32'h10B, 0, 0); tick();
    look(32'h40);   chk("tgt_align", 1, 1, 1, 32'h108, 0, 0, 0, 0); tick();

    // Alias at index 0: 0x80 replaces 0x40.
    upd(32'h40, 32'h80, 1, 32'h200, 0, 0);
    chk("alias_pre", 1, 1, 1, 32'h108, 0, 0, 0, 0); tick();
    look(32'h40);   chk("alias_old", 1, 0, 0, 32'h44, 0, 0, 0, 0); tick();
    look(32'h80);   chk("alias_new", 1, 1, 1, 32'h200, 0, 0, 0, 0); tick();

    // Not-taken miss for 0xC0 leaves the 0x80 entry alone.
    upd(32'h4, 32'hC0, 0, 32'h0, 0, 0); tick();
    look(32'h80);   chk("nt_keep", 1, 1, 1, 32'h200, 0, 0, 0, 0); tick();
    look(32'hC0);   chk("nt_no_alloc", 1, 0, 0, 32'hC4, 0, 0, 0, 0); tick();

    // Reset overrides a same-cycle update and flush.
    drive(1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h700, 1'b1, 1'b1); tick();
    look(32'h300);  chk("rst_ovr", 1, 0, 0, 32'h304, 1, 0, 0, 0); tick();
    look(32'h80);   chk("rst_clr", 1, 0, 0, 32'h84, 0, 0, 0, 0); tick();

    // Flush wins over a same-cycle update, which is still counted.
    upd(32'h4, 32'h200, 1, 32'h300, 0, 0); tick();
    look(32'h200);  chk("alloc2", 1, 1, 1, 32'h300, 1, 0, 1, 0); tick();
    upd(32'h4, 32'h200, 1, 32'h400, 1, 1); tick();
    look(32'h200);  chk("flush_miss", 1, 0, 0, 32'h204, 1, 1, 2, 1); tick();
    upd(32'h4, 32'h200, 1, 32'h500, 0, 0); tick();
    look(32'h200);  chk("post_flush", 1, 1, 1, 32'h500, 1, 1, 3, 1); tick();

    // 20 mispredicting not-taken misses: update/mispredict counters saturate.
    for (int k = 0; k < 20; k++) begin
      upd(32'h4, 32'h4, 0, 32'h0, 1, 0);
      chk("mis_sat", 1, 0, 0, 32'h8, 1, 2, 3 + k, 1 + k); tick();
    end
    look(32'h4);    chk("mis_final", 1, 0, 0, 32'h8, 1, 2, 15, 15); tick();

    // Repeated hits saturate perf_hits.
    for (int k = 0; k < 16; k++) begin
      look(32'h200); chk("hit_sat", 1, 1, 1, 32'h500, 1, 2 + k, 15, 15); tick();
    end
    look(32'h4);    chk("hit_final", 1, 0, 0, 32'h8, 1, 15, 15, 15); tick();

    // Mid-stream reset clears entries and counters.
    drive(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h600, 1'b1, 1'b0); tick();
    look(32'h200);  chk("mid_rst", 1, 0, 0, 32'h204, 1, 0, 0, 0); tick();

    // Sequential next PC wraps at the top of the address space.
    look(32'hFFFF_FFFC); chk("pc_wrap", 1, 0, 0, 32'h0, 1, 0, 0, 0); tick();

    tick();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
